led_module: RTL
===============

LED_MODULE -- requirements
Module: led_module

Interface
REQ-001 SHALL have parameter RESET_PERIOD, default 24'd13_499_999, giving the blink half-period reset value in clk cycles minus one.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port wen  input  1  bus write strobe, one cycle per write.
REQ-005 SHALL have port ren  input  1  bus read strobe, one cycle per read.
REQ-006 SHALL have port address  input  32  byte address; only address[2:0] decoded.
REQ-007 SHALL have port data_in  input  32  write data.
REQ-008 SHALL have port data_out  output  32  registered read data.
REQ-009 SHALL have port led_n  output  4  board LEDs, active-low (0 = lit).

Function
REQ-010 SHALL decode registers on address[2:0]:
- 0 VALUE: bits [3:0], static LED on/off.
- 1 BLINK: bits [3:0], per-LED blink enable.
- 2 PERIOD: bits [23:0].
- 3 DUTY: bits [7:0].
- 4 STATUS: read-only {27'b0, phase, led_on[3:0]}.
REQ-011 SHALL, on wen, update the addressed register at that clock edge, using only the listed bits; writes to 4..7 SHALL be ignored.
REQ-012 SHALL, on ren, load data_out at that edge with the addressed register, zero-extended; unmapped addresses SHALL return 32'h0; data_out SHALL hold its value when ren=0.
REQ-013 SHALL, when ren and wen target the same register in one cycle, return the pre-write value.
REQ-014 SHALL run a 24-bit blink counter: if counter==PERIOD, clear it to 0 and toggle phase; otherwise increment it.
REQ-015 SHALL make PERIOD=0 toggle phase every cycle.
REQ-016 SHALL, on a PERIOD write, clear the counter to 0 and set phase=1 at that edge.
REQ-017 SHALL, when a PERIOD write is made below the current count, not let the counter overrun; this is guaranteed by REQ-016.
REQ-018 SHALL run a free-running 8-bit PWM counter that wraps 255->0; pwm_on = (pwm_cnt < DUTY).
REQ-019 SHALL give DUTY=0 as always dark and DUTY=255 as lit 255 of 256 cycles.
REQ-020 SHALL compute led_on[i] = VALUE[i] & (~BLINK[i] | phase) & pwm_on.
REQ-021 SHALL register led_n = ~led_on, so a register write appears on led_n exactly 1 cycle after the write edge.
REQ-022 SHALL, when both blink and PWM are active, gate PWM within the blink on-phase, with no interaction between the two counters.

Reset
REQ-023 SHALL, while rst=1, asynchronously force:
- VALUE=0, BLINK=0, PERIOD=RESET_PERIOD, DUTY=8'hFF;
- blink counter=0, phase=1, pwm_cnt=0;
- data_out=32'h0, led_n=4'hF.
REQ-024 SHALL, on reset asserted mid-blink or mid-read, abandon that operation with no residual state; the first post-reset edge behaves as from power-up.
REQ-025 SHALL ignore wen and ren while rst=1.

Verification
REQ-026 Reset check: assert rst during activity -> led_n=4'hF and data_out=0 immediately; reading STATUS after release -> 32'h10.
REQ-027 Static/readback check:
- write VALUE=32'hFFFF_FFF5, DUTY=255 -> led_n=4'b1010 one cycle later;
- read 0 -> data_out=32'h5.
REQ-028 Blink check: VALUE=4'hF, BLINK=4'h1, PERIOD=3 -> led_n[0] alternates 4 cycles lit / 4 dark, synchronised to the PERIOD write; led_n[3:1] stay 0.
REQ-029 PWM check: VALUE=4'hF, BLINK=0, DUTY=64 -> each LED lit exactly 64 of every 256 cycles; DUTY=0 -> led_n=4'hF continuously.
REQ-030 Collision/unmapped check:
- same-cycle ren+wen to addr 3, old DUTY=255, new 16 -> data_out=32'hFF;
- write to addr 6 -> no register changes;
- read addr 7 -> 32'h0.
REQ-031 Edge-case check: PERIOD=0 -> phase toggles every cycle; then write PERIOD=5 while the counter is mid-count -> counter=0, phase=1 on the next cycle.

Source files
------------

// File: rtl/led_module.sv
// LED controller with a small register bank: static on/off, per-LED blink,
// programmable blink half-period and a free-running PWM dimmer.
// Read data and the LED pins are both registered.
module led_module #(
    parameter logic [23:0] RESET_PERIOD = 24'd13_499_999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  led_n
);

    localparam logic [2:0] A_VALUE  = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_DUTY   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic [3:0]  value_q,  value_d;
    logic [3:0]  blink_q,  blink_d;
    logic [23:0] period_q, period_d;
    logic [7:0]  duty_q,   duty_d;
    logic [23:0] cnt_q,    cnt_d;
    logic        phase_q,  phase_d;
    logic [7:0]  pwm_q,    pwm_d;
    logic [31:0] data_out_q, data_out_d;
    logic [3:0]  led_n_q,  led_n_d;

    logic [2:0]  addr;
    logic        period_wr;
    logic        pwm_on;
    logic [3:0]  led_on;

    // Only the low address bits and the listed data bits are decoded.
    logic unused_bits;
    assign unused_bits = ^{address[31:3], data_in[31:24]};

    assign addr      = address[2:0];
    assign period_wr = wen && (addr == A_PERIOD);

    // Register bank writes; addresses 4..7 are not writable.
    always_comb begin
        value_d  = value_q;
        blink_d  = blink_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wen) begin
            case (addr)
                A_VALUE:  value_d  = data_in[3:0];
                A_BLINK:  blink_d  = data_in[3:0];
                A_PERIOD: period_d = data_in[23:0];
                A_DUTY:   duty_d   = data_in[7:0];
                default:  ;
            endcase
        end
    end

    // Blink half-period counter; a PERIOD write restarts it in the on-phase,
    // so a shorter period can never leave the count stranded above it.
    always_comb begin
        cnt_d   = cnt_q + 24'd1;
        phase_d = phase_q;
        if (period_wr) begin
            cnt_d   = 24'd0;
            phase_d = 1'b1;
        end else if (cnt_q == period_q) begin
            cnt_d   = 24'd0;
            phase_d = ~phase_q;
        end
    end

    // Free-running PWM counter and LED combine; PWM gates within blink on-phase.
    always_comb begin
        pwm_d   = pwm_q + 8'd1;
        pwm_on  = (pwm_q < duty_q);
        led_on  = value_q & (~blink_q | {4{phase_q}}) & {4{pwm_on}};
        led_n_d = ~led_on;
    end

    // Read mux samples the pre-write register contents; holds when idle.
    always_comb begin
        data_out_d = data_out_q;
        if (ren) begin
            case (addr)
                A_VALUE:  data_out_d = {28'b0, value_q};
                A_BLINK:  data_out_d = {28'b0, blink_q};
                A_PERIOD: data_out_d = {8'b0, period_q};
                A_DUTY:   data_out_d = {24'b0, duty_q};
                A_STATUS: data_out_d = {27'b0, phase_q, led_on};
                default:  data_out_d = 32'h0;
            endcase
        end
    end

    // State registers with asynchronous reset to power-up values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= 4'h0;
            blink_q    <= 4'h0;
            period_q   <= RESET_PERIOD;
            duty_q     <= 8'hFF;
            cnt_q      <= 24'd0;
            phase_q    <= 1'b1;
            pwm_q      <= 8'd0;
            data_out_q <= 32'h0;
            led_n_q    <= 4'hF;
        end else begin
            value_q    <= value_d;
            blink_q    <= blink_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pwm_q      <= pwm_d;
            data_out_q <= data_out_d;
            led_n_q    <= led_n_d;
        end
    end

    assign data_out = data_out_q;
    assign led_n    = led_n_q;

endmodule
